// File: rtl/div_pkg.sv
// div_pkg: shared encodings and constants for the EX-stage DIV/HI/LO controller
package div_pkg;
   localparam int DATA_W    = 16;
   localparam int TIMEOUT   = 31;
   localparam int RST_QUIET = 20;
   localparam int CNT_W     = 5;
   localparam logic [DATA_W-1:0] LO_DIV0 = 16'hFFFF;
   localparam logic [DATA_W-1:0] MIN_NEG = 16'h8000;
   typedef enum logic [2:0] {QUIET, IDLE, ISSUE, WAIT, DRAIN} state_t;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate, used as abs() on operands and sign restore on results
module div_sign_fix
   import div_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic              neg,
   output logic [DATA_W-1:0] y
);
   assign y = neg ? -a : a;
endmodule

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences signed DIV through a magnitude-only divider, owns HI/LO and the EX stall
module div_hilo_ctrl
   import div_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_div_req,
   input  logic              ex_flush,
   input  logic [DATA_W-1:0] ex_rs,
   input  logic [DATA_W-1:0] ex_rt,
   input  logic              ex_mthi,
   input  logic              ex_mtlo,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              stall,
   output logic              div_err,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_ready,
   input  logic [31:0]       div_result
);
   state_t            state, next_state;
   logic [CNT_W-1:0]  quiet_cnt, to_cnt;
   logic              neg_q, neg_r, done;
   logic [DATA_W-1:0] abs_rs, abs_rt, q_fix, r_fix;
   logic              req, fast_zero, fast_min, fast, commit, to_hit, timeout, issue;

   div_sign_fix u_abs_rs (.a(ex_rs),              .neg(ex_rs[DATA_W-1]), .y(abs_rs));
   div_sign_fix u_abs_rt (.a(ex_rt),              .neg(ex_rt[DATA_W-1]), .y(abs_rt));
   div_sign_fix u_fix_q  (.a(div_result[31:16]),  .neg(neg_q),           .y(q_fix));
   div_sign_fix u_fix_r  (.a(div_result[15:0]),   .neg(neg_r),           .y(r_fix));

   // done marks the instruction still sitting in EX after its commit/abandon so it is not re-issued
   assign req       = ex_div_req && !ex_flush && !done;
   assign fast_zero = ex_rt == '0;
   assign fast_min  = ex_rt == MIN_NEG;
   assign fast      = fast_zero || fast_min;
   assign issue     = state == IDLE && req && !fast;
   assign commit    = state == WAIT && div_ready && !ex_flush;
   assign to_hit    = to_cnt == CNT_W'(TIMEOUT - 1);
   assign timeout   = state == WAIT && !div_ready && !ex_flush && to_hit;

   always_ff @(posedge clk)
      state <= rst ? QUIET : next_state;

   always_comb begin
      next_state = state;
      case (state)
         QUIET:   next_state = quiet_cnt == CNT_W'(RST_QUIET - 1) ? IDLE : QUIET;
         IDLE:    next_state = issue ? ISSUE : IDLE;
         ISSUE:   next_state = ex_flush ? DRAIN : WAIT;
         WAIT:    next_state = ex_flush ? DRAIN : div_ready ? IDLE : to_hit ? QUIET : WAIT;
         DRAIN:   next_state = (div_ready || to_hit) ? IDLE : DRAIN;
         default: next_state = QUIET;
      endcase
   end

   always_comb begin
      div_start = state == ISSUE;
      stall     = state == QUIET || state == ISSUE || state == WAIT || issue ||
                  (state == DRAIN && ex_div_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quiet_cnt    <= '0;
         to_cnt       <= '0;
         div_err      <= 1'b0;
         done         <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         hi_out       <= '0;
         lo_out       <= '0;
      end else begin
         quiet_cnt <= state == QUIET ? quiet_cnt + 1'b1 : '0;
         to_cnt    <= (next_state == state && (state == WAIT || state == DRAIN)) ? to_cnt + 1'b1 : '0;
         div_err   <= timeout;
         done      <= (commit || timeout) ? 1'b1 : state == IDLE ? 1'b0 : done;
         if (issue) begin
            div_dividend <= abs_rs;
            div_divisor  <= abs_rt;
            neg_q        <= ex_rs[DATA_W-1] ^ ex_rt[DATA_W-1];
            neg_r        <= ex_rs[DATA_W-1];
         end
         if (state == IDLE && req && fast) begin
            lo_out <= fast_zero ? LO_DIV0 : {{(DATA_W-1){1'b0}}, ex_rs == MIN_NEG};
            hi_out <= (fast_min && ex_rs == MIN_NEG) ? '0 : ex_rs;
         end else if (state == IDLE && !ex_div_req) begin
            if (ex_mthi) hi_out <= ex_rs;
            if (ex_mtlo) lo_out <= ex_rs;
         end else if (commit) begin
            lo_out <= q_fix;
            hi_out <= r_fix;
         end
      end
   end
endmodule
